// File: rtl/pipeline_adder_n.sv
// Pipelined carry-chain adder/subtractor: WIDTH bits split into STAGES chunks, skewed in, deskewed out.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipeline_adder_n #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             enable,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             stall;

    assign b_eff     = sub ? ~b : b;
    assign c0        = cin ^ sub;
    assign out_valid = g_st[STAGES-1].v_q;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    // Stage s owns operand chunks j > s (skew) and result chunks j <= s (deskew).
    for (genvar s = 0; s < STAGES; s++) begin : g_st
        logic             v_q, c_q, v_in, c_in, load;
        logic [CHUNK-1:0] op_a, op_b;
        logic [CHUNK:0]   add;

        if (s == 0) begin : g_head
            assign v_in = in_valid;
            assign c_in = c0;
            assign op_a = a[CHUNK-1:0];
            assign op_b = b_eff[CHUNK-1:0];
        end else begin : g_head
            assign v_in = g_st[s-1].v_q;
            assign c_in = g_st[s-1].c_q;
            assign op_a = g_st[s-1].g_ch[s].g_skew.a_q;
            assign op_b = g_st[s-1].g_ch[s].g_skew.b_q;
        end

        // Data registers only load real transactions so outputs hold across bubbles.
        assign load = ~stall & v_in;
        assign add  = {1'b0, op_a} + {1'b0, op_b} + {{CHUNK{1'b0}}, c_in};

        always_ff @(posedge enable) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
            end else begin
                if (!stall) v_q <= v_in;
                if (load)   c_q <= add[CHUNK];
            end
        end

        for (genvar j = 0; j < STAGES; j++) begin : g_ch
            if (j > s) begin : g_skew
                logic [CHUNK-1:0] a_q, b_q, a_d, b_d;
                if (s == 0) begin : g_src
                    assign a_d = a[j*CHUNK +: CHUNK];
                    assign b_d = b_eff[j*CHUNK +: CHUNK];
                end else begin : g_src
                    assign a_d = g_st[s-1].g_ch[j].g_skew.a_q;
                    assign b_d = g_st[s-1].g_ch[j].g_skew.b_q;
                end
                always_ff @(posedge enable) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (load) begin
                        a_q <= a_d;
                        b_q <= b_d;
                    end
                end
            end else begin : g_res
                logic [CHUNK-1:0] r_q, r_d;
                if (j == s) begin : g_src
                    assign r_d = add[CHUNK-1:0];
                end else begin : g_src
                    assign r_d = g_st[s-1].g_ch[j].g_res.r_q;
                end
                always_ff @(posedge enable) begin
                    if (rst)       r_q <= '0;
                    else if (load) r_q <= r_d;
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (s == STAGES-1) begin : g_ovf
            logic ovf_q, msb_cin;
            assign msb_cin = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ add[CHUNK-1];
            always_ff @(posedge enable) begin
                if (rst)       ovf_q <= 1'b0;
                else if (load) ovf_q <= msb_cin ^ add[CHUNK];
            end
        end
`endif
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_out
        assign sum[j*CHUNK +: CHUNK] = g_st[STAGES-1].g_ch[j].g_res.r_q;
    end
    assign cout = g_st[STAGES-1].c_q;

`ifdef PIPE_ADDER_OVF_EN
    assign ovf = g_st[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipeline_adder_n.sv
// Self-checking bench for pipeline_adder_n: an 8-bit/2-stage and a 16-bit/4-stage instance
// checked against a full-precision arithmetic reference model.
module tb_pipeline_adder_n;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16, cout16;
    logic [15:0] a16, b16, sum16;
`ifdef PIPE_ADDER_OVF_EN
    logic        ovf8, ovf16;
`endif

    pipeline_adder_n #(.WIDTH(8), .STAGES(2)) dut8 (
        .enable(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    pipeline_adder_n #(.WIDTH(16), .STAGES(4)) dut16 (
        .enable(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16), .cout(cout16)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf16)
`endif
    );

    // Reference: full-precision a + B' + C0; bit w is cout.
    function automatic longint full_ref(longint x, longint y, bit ci, bit sb, int w);
        longint m  = (longint'(1) << w) - 1;
        longint yy = sb ? (~y & m) : y;
        return x + yy + longint'(ci ^ sb);
    endfunction

    function automatic bit ovf_ref(longint x, longint y, bit ci, bit sb, int w);
        longint half = longint'(1) << (w - 1);
        longint m    = (longint'(1) << w) - 1;
        longint yy   = sb ? (~y & m) : y;
        longint sx   = (x >= half) ? x - 2 * half : x;
        longint sy   = (yy >= half) ? yy - 2 * half : yy;
        longint r    = sx + sy + longint'(ci ^ sb);
        return (r >= half) || (r < -half);
    endfunction

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb,
                        output logic [7:0] s, output logic co, output logic ov, output int lat);
        a8 = av; b8 = bv; cin8 = ci; sub8 = sb; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid8) lat = -1;
        s = sum8; co = cout8;
`ifdef PIPE_ADDER_OVF_EN
        ov = ovf8;
`else
        ov = 1'b0;
`endif
        @(posedge clk); #1;
    endtask

    task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb,
                         output logic [15:0] s, output logic co, output int lat);
        a16 = av; b16 = bv; cin16 = ci; sub16 = sb; in_valid16 = 1'b1; out_ready16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid16) lat = -1;
        s = sum16; co = cout16;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid8 = 1'b1; a8 = 8'h55; b8 = 8'h33;
        in_valid16 = 1'b1; a16 = 16'h1234; b16 = 16'h4321;
        out_ready8 = 1'b0; out_ready16 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL reset_in_ready8 got=%b exp=1", in_ready8); end
        checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid8 got=%b exp=0", out_valid8); end
        checks++; if (sum8 !== 8'h00 || cout8 !== 1'b0) begin failures++; $display("FAIL reset_data8 sum=%h cout=%b exp 00/0", sum8, cout8); end
        checks++; if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin failures++; $display("FAIL reset_hs16 ov=%b ir=%b exp 0/1", out_valid16, in_ready16); end
        checks++; if (sum16 !== 16'h0000 || cout16 !== 1'b0) begin failures++; $display("FAIL reset_data16 sum=%h cout=%b exp 0000/0", sum16, cout16); end
`ifdef PIPE_ADDER_OVF_EN
        checks++; if (ovf8 !== 1'b0 || ovf16 !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b%b exp=00", ovf8, ovf16); end
`endif
        rst = 1'b0; in_valid8 = 1'b0; in_valid16 = 1'b0; out_ready8 = 1'b1; out_ready16 = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin failures++; $display("FAIL post_reset8 ir=%b ov=%b exp 1/0", in_ready8, out_valid8); end
    endtask

    task automatic test_add_sub8();
        logic [7:0] ta [5] = '{8'h0F, 8'hFF, 8'h05, 8'h07, 8'h07};
        logic [7:0] tb [5] = '{8'h01, 8'h01, 8'h07, 8'h05, 8'h05};
        logic       tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] es [5] = '{8'h10, 8'h00, 8'hFE, 8'h02, 8'h01};
        logic       ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] s;
        logic       co, ov;
        int         lat;
        for (int i = 0; i < 5; i++) begin
            run8(ta[i], tb[i], tc[i], ts[i], s, co, ov, lat);
            checks++; if (s !== es[i]) begin failures++; $display("FAIL addsub_sum[%0d] got=%h exp=%h", i, s, es[i]); end
            checks++; if (co !== ec[i]) begin failures++; $display("FAIL addsub_cout[%0d] got=%b exp=%b", i, co, ec[i]); end
            checks++; if (lat != 2) begin failures++; $display("FAIL addsub_latency[%0d] got=%0d exp=2", i, lat); end
        end
`ifdef PIPE_ADDER_OVF_EN
        begin
            logic [7:0] oa [3] = '{8'h7F, 8'h80, 8'h01};
            logic [7:0] ob [3] = '{8'h01, 8'h01, 8'h01};
            logic       os [3] = '{1'b0, 1'b1, 1'b0};
            logic [7:0] oe [3] = '{8'h80, 8'h7F, 8'h02};
            logic       ov_e [3] = '{1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 3; i++) begin
                run8(oa[i], ob[i], 1'b0, os[i], s, co, ov, lat);
                checks++; if (s !== oe[i]) begin failures++; $display("FAIL ovf_sum[%0d] got=%h exp=%h", i, s, oe[i]); end
                checks++; if (ov !== ov_e[i]) begin failures++; $display("FAIL ovf_flag[%0d] got=%b exp=%b", i, ov, ov_e[i]); end
            end
        end
`endif
    endtask

    task automatic test_back_to_back8();
        longint exp_q[$];
        bit     ovq[$];
        int     tq[$];
        int     sent = 0, got = 0, cyc = 0;
        while (got < 20 && cyc < 100) begin
            in_valid8 = (sent < 20);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
            out_ready8 = 1'b1;
            #1;
            checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", cyc, in_ready8); end
            if (out_valid8 && out_ready8) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL b2b_extra_output sum=%h exp=none", sum8);
                end else begin
                    longint e = exp_q.pop_front();
                    int     t = tq.pop_front();
                    bit     eo = ovq.pop_front();
                    checks++; if ({cout8, sum8} !== 9'(e)) begin failures++; $display("FAIL b2b_result got=%h exp=%h", {cout8, sum8}, 9'(e)); end
                    checks++; if (cyc - t != 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", cyc - t); end
`ifdef PIPE_ADDER_OVF_EN
                    checks++; if (ovf8 !== eo) begin failures++; $display("FAIL b2b_ovf got=%b exp=%b", ovf8, eo); end
`else
                    if (eo) ;
`endif
                    got++;
                end
            end
            if (in_valid8 && in_ready8) begin
                exp_q.push_back(full_ref(longint'(a8), longint'(b8), cin8, sub8, 8));
                ovq.push_back(ovf_ref(longint'(a8), longint'(b8), cin8, sub8, 8));
                tq.push_back(cyc);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid8 = 1'b0;
        checks++; if (got != 20 || cyc != 22) begin failures++; $display("FAIL b2b_throughput got=%0d cycles=%0d exp 20/22", got, cyc); end
    endtask

    task automatic test_backpressure8();
        logic [7:0] got_q[$];
        int         sent = 0, hold = 0, cyc = 0;
        bit         first_seen = 0, prev_stall = 0;
        logic [7:0] prev_sum = '0;
        while (got_q.size() < 3 && cyc < 40) begin
            if (prev_stall) begin
                checks++; if (sum8 !== prev_sum) begin failures++; $display("FAIL bp_sum_stable got=%h exp=%h", sum8, prev_sum); end
            end
            in_valid8 = (sent < 3);
            a8 = 8'(sent + 1); b8 = 8'(sent + 1); cin8 = 1'b0; sub8 = 1'b0;
            if (out_valid8 && !first_seen) begin first_seen = 1; hold = 3; end
            out_ready8 = (hold == 0);
            if (hold > 0) hold--;
            #1;
            checks++; if (in_ready8 !== !(out_valid8 && !out_ready8)) begin failures++; $display("FAIL bp_in_ready got=%b ov=%b or=%b", in_ready8, out_valid8, out_ready8); end
            if (out_valid8 && out_ready8) got_q.push_back(sum8);
            if (in_valid8 && in_ready8) sent++;
            prev_stall = out_valid8 && !out_ready8;
            prev_sum = sum8;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        checks++; if (got_q.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            checks++; if (got_q[i] !== 8'(2 * (i + 1))) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got_q[i], 8'(2 * (i + 1))); end
        end
        checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL bp_duplicate out_valid=%b exp=0", out_valid8); end
    endtask

    task automatic test_reset_midflight16();
        logic [15:0] s;
        logic        co;
        int          lat;
        out_ready16 = 1'b1;
        in_valid16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; sub16 = 1'b0;
        @(posedge clk); #1;
        a16 = 16'h3333; b16 = 16'h4444;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        checks++; if (out_valid16 !== 1'b0) begin failures++; $display("FAIL midrst_pre_emerge got=%b exp=0", out_valid16); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid16 !== 1'b0 || sum16 !== 16'h0 || cout16 !== 1'b0) begin
                failures++; $display("FAIL midrst_flush[%0d] ov=%b sum=%h cout=%b exp 0/0000/0", i, out_valid16, sum16, cout16);
            end
            @(posedge clk); #1;
        end
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, lat);
        checks++; if ({co, s} !== 17'h10000) begin failures++; $display("FAIL midrst_next_result got=%h exp=10000", {co, s}); end
        checks++; if (lat != 4) begin failures++; $display("FAIL midrst_next_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_random_stream16();
        longint      exp_q[$];
        bit          ovq[$];
        int          tq[$];
        int          sent = 0, cyc = 0;
        bit          prev_stall = 0;
        logic [15:0] prev_sum = '0;
        logic        prev_cout = 1'b0;
        while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            if (prev_stall) begin
                checks++; if (sum16 !== prev_sum || cout16 !== prev_cout) begin failures++; $display("FAIL rnd_stall_hold got=%h exp=%h", {cout16, sum16}, {prev_cout, prev_sum}); end
            end
            in_valid16 = (sent < 1000) && ($urandom_range(3) != 0);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'($urandom);
            out_ready16 = ($urandom_range(9) < 7);
            #1;
            checks++; if (in_ready16 !== !(out_valid16 && !out_ready16)) begin failures++; $display("FAIL rnd_in_ready got=%b ov=%b or=%b", in_ready16, out_valid16, out_ready16); end
            if (out_valid16 && out_ready16) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL rnd_extra_output sum=%h exp=none", sum16);
                end else begin
                    longint e = exp_q.pop_front();
                    int     t = tq.pop_front();
                    bit     eo = ovq.pop_front();
                    checks++; if ({cout16, sum16} !== 17'(e)) begin failures++; $display("FAIL rnd_result got=%h exp=%h", {cout16, sum16}, 17'(e)); end
                    checks++; if (cyc - t < 4) begin failures++; $display("FAIL rnd_latency got=%0d exp>=4", cyc - t); end
`ifdef PIPE_ADDER_OVF_EN
                    checks++; if (ovf16 !== eo) begin failures++; $display("FAIL rnd_ovf got=%b exp=%b", ovf16, eo); end
`else
                    if (eo) ;
`endif
                end
            end
            if (in_valid16 && in_ready16) begin
                exp_q.push_back(full_ref(longint'(a16), longint'(b16), cin16, sub16, 16));
                ovq.push_back(ovf_ref(longint'(a16), longint'(b16), cin16, sub16, 16));
                tq.push_back(cyc);
                sent++;
            end
            prev_stall = out_valid16 && !out_ready16;
            prev_sum = sum16;
            prev_cout = cout16;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        checks++; if (sent != 1000 || exp_q.size() != 0) begin failures++; $display("FAIL rnd_completion sent=%0d pending=%0d exp 1000/0", sent, exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_add_sub8();
        test_back_to_back8();
        test_backpressure8();
        test_reset_midflight16();
        test_random_stream16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_adder_n.md
# pipeline_adder_n

Parametrised pipelined carry-chain adder/subtractor. It splits a WIDTH-bit add into STAGES equal chunks, one chunk per pipeline stage, and passes the inter-chunk carry through registers. Input operands are skewed and output chunks are deskewed, so each result emerges as one aligned word. It generalises the two-stage 8-bit pipeline adder in basic_circuits: configurable width and depth, per-transaction subtract mode, and a valid/ready handshake with backpressure.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of STAGES.
- STAGES, 2, pipeline stages (1..WIDTH); CHUNK = WIDTH/STAGES bits added per stage.
- enable  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept; a transfer occurs when in_valid & in_ready at a rising edge.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in.
- sub  in  1  1 = subtract (A + ~B + ~cin... see Operation), 0 = add.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (for subtract: 1 = no borrow).
- ovf  out  1  signed overflow; exists only with PIPE_ADDER_OVF_EN.

## Operation
- Effective operand: B' = sub ? ~b : b; effective carry C0 = cin ^ sub. sub=1 with cin=0 gives a−b; sub=1 with cin=1 gives a−b−1.
- Stage k (1..STAGES) adds chunk k−1 of A and B' plus the carry registered by stage k−1 (C0 for stage 1). It registers the CHUNK-bit partial sum and the carry out.
- Upper operand chunks are delayed in skew registers so that they arrive at their stage in step with the carry. Lower result chunks are delayed in deskew registers so that all chunks leave together.
- Width rule: sum = (A + B' + C0) mod 2^WIDTH; cout = bit WIDTH of the full-precision result.
- Each stage carries a valid bit. out_valid is the last stage's valid bit.
- Global stall: stall = out_valid & ~out_ready. When stalled, every stage, skew and deskew register holds its value. in_ready = ~stall, and is combinational from out_valid/out_ready.
- Bubbles are not collapsed. An empty stage advances like a full one, and its valid bit carries 0.
- Order is preserved; no transaction is dropped or duplicated.
- STAGES=1: a single registered adder with the same handshake.
- Reset: on any edge with rst=1, all valid bits, data registers, sum, cout and ovf clear to 0. An in-flight transaction is discarded and no partial result is emitted. in_ready reads 1 during and after reset, because out_valid=0.

## Timing
- Latency is STAGES rising edges including the accepting edge. If accepted at edge N with no stall, out_valid=1 and sum/cout are stable after edge N+STAGES−1.
- Throughput is one transaction per cycle while out_ready=1.
- A stall of S cycles adds exactly S cycles to every transaction in flight.
- Simultaneous in-transfer and out-transfer in the same cycle is legal and required for full throughput.
- sum/cout/ovf are registered outputs. They change only on an edge where the last stage advances, and otherwise hold (including while out_valid=0).
- rst takes priority over in_valid and over stall.

## Configuration
- PIPE_ADDER_OVF_EN defined: the ovf port exists. ovf is computed in the final stage as carry-into-MSB XOR carry-out-of-MSB, and is aligned with sum. It resets to 0.
- PIPE_ADDER_OVF_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, STAGES=2: a=0x0F, b=0x01, cin=0, sub=0 → 2 edges later sum=0x10, cout=0 (carry crosses chunk boundary). Then a=0xFF, b=0x01 → sum=0x00, cout=1.
- Subtract: a=0x05, b=0x07, sub=1, cin=0 → sum=0xFE, cout=0. Then a=0x07, b=0x05 → sum=0x02, cout=1.
- Backpressure: stream 0x01+0x01, 0x02+0x02, 0x03+0x03 with out_ready=0 for 3 cycles after the first result. in_ready must be 0 exactly while out_valid&~out_ready. Results 0x02, 0x04, 0x06 must come out in order, each exactly once, and sum must be stable while stalled.
- Reset mid-flight: accept 2 transactions, assert rst for 1 cycle before either emerges. out_valid must stay 0, sum=0, cout=0, and the next accepted transaction must complete with correct latency.
- WIDTH=16, STAGES=4, back-to-back random streaming for 1000 transactions with random out_ready. Each output must equal the reference (a + B' + C0) with 4-edge minimum latency and no loss.
- With PIPE_ADDER_OVF_EN, WIDTH=8: a=0x7F+b=0x01 → sum=0x80, ovf=1. a=0x80, b=0x01, sub=1 → sum=0x7F, ovf=1. a=0x01+b=0x01 → ovf=0.
